// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter.
//   DATA_W   : memory data width
//   ADDR_W   : memory word-address width (32 words)
//   MAX_WAIT : consecutive loader denials before the loader is forced a grant
//   owner_e  : owner of the memory port during the previous cycle
package dmem_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int MAX_WAIT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_P = 2'd1,
        OWN_L = 2'd2
    } owner_e;

endpackage

// File: rtl/dmem_starve_cnt.sv
// Loader anti-starvation counter.
// Counts consecutive cycles in which the loader requests and is refused.
// Once the count reaches MAX_WAIT the force flag is raised, and the next
// arbitration hands the memory to the loader.
//   clk     in  rising-edge clock
//   rst_n   in  synchronous, active-low reset
//   l_req   in  loader request
//   l_gnt   in  loader granted this cycle
//   force_l out loader must win the next contested cycle
module dmem_starve_cnt #(
    parameter int MAX_WAIT = dmem_pkg::MAX_WAIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic l_req,
    input  logic l_gnt,
    output logic force_l
);
    import dmem_pkg::*;

    localparam int                CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!l_req || l_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign force_l = (wait_cnt == CNT_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing one single-port 32x32 data memory between the pipeline MEM
// stage (port P, normally wins) and a program/data loader (port L). One access
// per cycle; the loser is held and the pipeline is stalled when it loses.
// The loader is guaranteed a slot after MAX_WAIT consecutive denials.
//   clk, rst_n                      clock, synchronous active-low reset
//   p_req/p_we/p_addr/p_wdata       pipeline request (in)
//   p_stall                         pipeline requested but not granted (comb)
//   p_rvalid/p_rdata                pipeline read response, 1-cycle latency
//   l_req/l_we/l_addr/l_wdata       loader request, held until l_gnt (in)
//   l_gnt                           loader accepted this cycle (comb)
//   l_rvalid/l_rdata                loader read response, 1-cycle latency
//   mem_wr_en/mem_rd_en/mem_addr/mem_wdata  to the memory
//   mem_rdata                       from the memory (combinational read)
module dmem_arbiter #(
    parameter int DATA_W   = dmem_pkg::DATA_W,
    parameter int ADDR_W   = dmem_pkg::ADDR_W,
    parameter int MAX_WAIT = dmem_pkg::MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_stall,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    import dmem_pkg::*;

    owner_e state, next_state;
    logic   p_gnt;
    logic   force_l;
    logic   last_rd;   // previous cycle's granted access was a read

    dmem_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .l_req   (l_req),
        .l_gnt   (l_gnt),
        .force_l (force_l)
    );

    // Grant, next owner and memory port mux. Holding rst_n low masks every
    // grant, which also suppresses a write that would otherwise commit at
    // the reset edge.
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        p_gnt      = 1'b0;
        l_gnt      = 1'b0;
        next_state = IDLE;
        mem_wr_en  = 1'b0;
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        if (rst_n) begin
            if (l_req && (!p_req || force_l)) begin
                l_gnt = 1'b1;
            end else if (p_req) begin
                p_gnt = 1'b1;
            end
        end

        if (p_gnt) begin
            next_state = OWN_P;
            mem_wr_en  = p_we;
            mem_rd_en  = !p_we;
            mem_addr   = p_addr;
            mem_wdata  = p_wdata;
        end else if (l_gnt) begin
            next_state = OWN_L;
            mem_wr_en  = l_we;
            mem_rd_en  = !l_we;
            mem_addr   = l_addr;
            mem_wdata  = l_wdata;
        end
    end

    assign p_stall = rst_n && p_req && !p_gnt;

    // Owner register plus read-response capture. The read data registers are
    // only loaded by a read on their own port, so they hold between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            last_rd <= 1'b0;
            p_rdata <= '0;
            l_rdata <= '0;
        end else begin
            state   <= next_state;
            last_rd <= mem_rd_en;
            if (p_gnt && !p_we) begin
                p_rdata <= mem_rdata;
            end
            if (l_gnt && !l_we) begin
                l_rdata <= mem_rdata;
            end
        end
    end

    // A response is valid for the single cycle after a granted read; the
    // owner register tells which port it belongs to.
    assign p_rvalid = (state == OWN_P) && last_rd;
    assign l_rvalid = (state == OWN_L) && last_rd;

endmodule
